// File: rtl/psg_pkg.sv
// Shared types and helpers for the SN76489 write scheduler.
package psg_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} psg_wr_state_t;

  localparam int LATCH_BIT = 7;
  localparam int TYPE_BIT  = 4;

  // Tone 0-2 frequency latch: first byte of a two-byte frequency write.
  function automatic logic is_pair_latch(logic [7:0] b);
    return b[LATCH_BIT] && !b[TYPE_BIT] && (b[6:5] != 2'b11);
  endfunction

endpackage

// File: rtl/psg_rr_arb2.sv
// Two-way round-robin arbiter; the requester that did not win last time wins a tie.
module psg_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] elig_i,
  input  logic       adv_i,
  output logic       gnt_o,
  output logic       gnt_vld_o
);

  logic last_q;

  always_comb begin
    gnt_vld_o = |elig_i;
    gnt_o     = 1'b0;
    if (elig_i == 2'b11) gnt_o = ~last_q;
    else                 gnt_o = elig_i[1];
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      last_q <= 1'b1;
    else if (adv_i && gnt_vld_o)    last_q <= gnt_o;
  end

endmodule

// File: rtl/psg_write_sched.sv
// Arbitrates two byte requesters onto the SN76489 write port, keeping
// tone-frequency latch/data pairs atomic and running the READY handshake.
module psg_write_sched
  import psg_pkg::*;
#(
  parameter int STROBE_TO = 64,
  parameter int LOCK_TO   = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       psg_nWE,
  output logic       psg_nCE,
  output logic [7:0] psg_D,
  input  logic       psg_READY,
  output logic       busy,
  output logic       lock_active,
  output logic       lock_owner,
  output logic [1:0] err,
  input  logic       err_clr
);

  localparam int SW = (STROBE_TO > 1) ? $clog2(STROBE_TO) : 1;
  localparam int LW = (LOCK_TO > 1)   ? $clog2(LOCK_TO)   : 1;
  localparam logic [SW-1:0] STB_MAX  = SW'(STROBE_TO - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TO - 1);

  psg_wr_state_t state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [LW-1:0] ltmr_q, ltmr_d;
  logic [7:0]    d_q, d_d;
  logic          lock_q, lock_d;
  logic          own_q, own_d;
  logic [1:0]    err_q, err_d;

  logic [1:0] elig;
  logic       gnt, gnt_vld, accept, own_acc, lock_expire, strobe_to;
  logic [7:0] acc_byte;

  // Eligibility uses the pre-edge lock, so a release and a grant never race.
  assign elig[0] = req_valid[0] && (!lock_q || !own_q);
  assign elig[1] = req_valid[1] && (!lock_q ||  own_q);

  psg_rr_arb2 u_arb (
    .clk_i     (CLK),
    .rst_i     (RST),
    .elig_i    (elig),
    .adv_i     (accept),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld)
  );

  assign accept   = (state_q == IDLE) && gnt_vld;
  assign acc_byte = gnt ? req_data1 : req_data0;

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    strobe_to = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE: begin
        if (!psg_READY) state_d = RELEASE;
        else if (scnt_q == STB_MAX) begin
          state_d   = RELEASE;
          strobe_to = 1'b1;
        end
      end
      RELEASE: begin
        if (psg_READY) state_d = IDLE;
        else if (scnt_q == STB_MAX) begin
          state_d   = IDLE;
          strobe_to = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    scnt_d = (state_d != state_q || state_q == IDLE) ? '0 : scnt_q + 1'b1;
  end

  // An owner accept in the expiry cycle clears the timer instead of erroring.
  assign own_acc     = accept && lock_q && (gnt == own_q);
  assign lock_expire = lock_q && !own_acc && (ltmr_q == LOCK_MAX);

  always_comb begin
    lock_d = lock_q;
    own_d  = own_q;
    d_d    = d_q;
    if (!lock_q || own_acc || lock_expire) ltmr_d = '0;
    else                                   ltmr_d = ltmr_q + 1'b1;
    if (accept) begin
      d_d = acc_byte;
      if (is_pair_latch(acc_byte)) begin
        lock_d = 1'b1;
        own_d  = gnt;
      end else if (own_acc) begin
        lock_d = 1'b0;
      end
    end else if (lock_expire) begin
      lock_d = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr)     err_d    = 2'b00;
    if (strobe_to)   err_d[0] = 1'b1;
    if (lock_expire) err_d[1] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      ltmr_q  <= '0;
      d_q     <= 8'h00;
      lock_q  <= 1'b0;
      own_q   <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      ltmr_q  <= ltmr_d;
      d_q     <= d_d;
      lock_q  <= lock_d;
      own_q   <= own_d;
      err_q   <= err_d;
    end
  end

  // Strobe decoded straight from the state register so reset drops it at once.
  assign psg_nWE     = (state_q != STROBE);
  assign psg_nCE     = (state_q != STROBE);
  assign psg_D       = d_q;
  assign busy        = (state_q != IDLE);
  assign lock_active = lock_q;
  assign lock_owner  = own_q;
  assign err         = err_q;

endmodule

// File: tb/tb_psg_write_sched.sv
// Randomized and directed bench for psg_write_sched with a transaction-level model.
module tb_psg_write_sched;

  localparam int STB = 64;
  localparam int LTO = 16;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [7:0] req_data0 = 8'h00, req_data1 = 8'h00;
  logic [1:0] req_ready;
  logic       psg_nWE, psg_nCE;
  logic [7:0] psg_D;
  logic       psg_READY = 1'b1;
  logic       busy, lock_active, lock_owner;
  logic [1:0] err;
  logic       err_clr = 1'b0;

  psg_write_sched #(.STROBE_TO(STB), .LOCK_TO(LTO)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .psg_nWE(psg_nWE),
    .psg_nCE(psg_nCE), .psg_D(psg_D), .psg_READY(psg_READY), .busy(busy),
    .lock_active(lock_active), .lock_owner(lock_owner), .err(err), .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;

  // Requester driver: each queue holds the bytes a requester still has to send.
  logic [7:0] dq0[$], dq1[$];
  logic [1:0] hs = 2'b00;
  int acc0 = 0, acc1 = 0, rdy0 = 0;

  always @(negedge CLK) begin
    if (hs[0]) begin void'(dq0.pop_front()); acc0++; end
    if (hs[1]) begin void'(dq1.pop_front()); acc1++; end
    hs = 2'b00;
    req_valid[0] = (dq0.size() != 0);
    req_data0    = (dq0.size() != 0) ? dq0[0] : 8'h00;
    req_valid[1] = (dq1.size() != 0);
    req_data1    = (dq1.size() != 0) ? dq1[0] : 8'h00;
    #4;
    if (!RST) begin
      hs = req_valid & req_ready;
      if (req_ready[0]) rdy0++;
    end
  end

  // PSG model and bus monitor.
  int dly = 2;
  bit stuck = 0;
  int lowcnt = 0, hicnt = 0, slen = 0, lock_len = 0, mon_err = 0;
  logic prev_nwe = 1'b1, prev_busy = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] bus_log[$];
  int len_log[$];

  always @(negedge CLK) begin
    if (RST) begin
      psg_READY = 1'b1; lowcnt = 0; hicnt = 0;
    end else if (!psg_nWE) begin
      hicnt = 0; lowcnt++;
      if (!stuck && lowcnt >= dly) psg_READY = 1'b0;
    end else begin
      lowcnt = 0;
      if (!psg_READY) begin
        hicnt++;
        if (hicnt >= 2) begin psg_READY = 1'b1; hicnt = 0; end
      end
    end
    if (prev_nwe && !psg_nWE) bus_log.push_back(psg_D);
    if (!psg_nWE) slen++;
    else if (!prev_nwe) begin len_log.push_back(slen); slen = 0; end
    if (lock_active) lock_len++;
    if (psg_nWE !== psg_nCE) mon_err++;
    if (!RST && psg_D !== prev_d && !(busy && !prev_busy)) mon_err++;
    prev_nwe = psg_nWE; prev_d = psg_D; prev_busy = busy;
  end

  // Transaction-level reference: every byte the requesters offer, in bus order.
  logic [7:0] m0[$], m1[$], exp_q[$];
  bit exp_lto, exp_lk, exp_own;

  function automatic void run_model(input bit last_in);
    bit lk = 0, own = 0, last = last_in, e0, e1, g;
    logic [7:0] b;
    exp_q.delete(); exp_lto = 0;
    while (m0.size() != 0 || m1.size() != 0) begin
      e0 = (m0.size() != 0) && (!lk || own == 1'b0);
      e1 = (m1.size() != 0) && (!lk || own == 1'b1);
      if (!e0 && !e1) begin lk = 0; exp_lto = 1; continue; end
      g = (e0 && e1) ? ~last : e1;
      b = g ? m1.pop_front() : m0.pop_front();
      exp_q.push_back(b);
      last = g;
      if (b[7] && (b[6:4] inside {3'b000, 3'b010, 3'b100})) begin lk = 1; own = g; end
      else if (lk && own == g) lk = 0;
    end
    exp_lk = lk; exp_own = own;
    if (lk) exp_lto = 1;
  endfunction

  task automatic tick();
    @(negedge CLK); #2;
  endtask

  task automatic do_reset();
    RST = 1'b1; dq0.delete(); dq1.delete();
    tick(); tick();
    RST = 1'b0; bus_log.delete(); len_log.delete();
    acc0 = 0; acc1 = 0; rdy0 = 0; lock_len = 0; mon_err = 0;
    tick();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while ((dq0.size() != 0 || dq1.size() != 0 || busy) && n < budget) begin tick(); n++; end
    ok = (n < budget);
  endtask

  task automatic wait_acc0(input int budget, output bit ok);
    int n = 0;
    while (acc0 < 1 && n < budget) begin tick(); n++; end
    ok = (n < budget);
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick();
    total += 8;
    if (psg_nWE !== 1'b1)   begin bad++; $display("FAIL reset_nWE got=%b want=1", psg_nWE); end
    if (psg_nCE !== 1'b1)   begin bad++; $display("FAIL reset_nCE got=%b want=1", psg_nCE); end
    if (psg_D !== 8'h00)    begin bad++; $display("FAIL reset_D got=%h want=00", psg_D); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (lock_active !== 1'b0) begin bad++; $display("FAIL reset_lock got=%b want=0", lock_active); end
    if (lock_owner !== 1'b0)  begin bad++; $display("FAIL reset_owner got=%b want=0", lock_owner); end
    if (err !== 2'b00)      begin bad++; $display("FAIL reset_err got=%b want=00", err); end
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    do_reset(); dly = 2; stuck = 0;
    dq0.push_back(8'h9F);
    wait_done(100, ok); tick(); tick();
    total += 7;
    if (!ok) begin bad++; $display("FAIL single_done got=timeout want=idle"); end
    if (bus_log.size() != 1 || bus_log[0] !== 8'h9F)
      begin bad++; $display("FAIL single_byte got=%0d/%h want=1/9f", bus_log.size(), bus_log[0]); end
    if (len_log.size() != 1 || len_log[0] != 2)
      begin bad++; $display("FAIL single_strobe_len got=%0d want=2", len_log[0]); end
    if (rdy0 != 1)      begin bad++; $display("FAIL single_ready_pulses got=%0d want=1", rdy0); end
    if (acc0 != 1)      begin bad++; $display("FAIL single_accepts got=%0d want=1", acc0); end
    if (err !== 2'b00)  begin bad++; $display("FAIL single_err got=%b want=00", err); end
    if (mon_err != 0)   begin bad++; $display("FAIL single_bus_rules got=%0d want=0", mon_err); end
  endtask

  task automatic test_tie_alternate();
    bit ok;
    do_reset();
    m0 = '{8'h9F, 8'h90, 8'h91, 8'h92}; m1 = '{8'hBF, 8'hB0, 8'hB1, 8'hB2};
    dq0 = m0; dq1 = m1;
    run_model(1'b1);
    wait_done(300, ok); tick();
    total += 2;
    if (!ok) begin bad++; $display("FAIL tie_done got=timeout want=idle"); end
    if (bus_log.size() != exp_q.size())
      begin bad++; $display("FAIL tie_count got=%0d want=%0d", bus_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
      total++;
      if (bus_log[i] !== exp_q[i]) begin bad++; $display("FAIL tie_order[%0d] got=%h want=%h", i, bus_log[i], exp_q[i]); end
    end
  endtask

  task automatic test_pair_lock();
    bit ok;
    do_reset();
    dq0.push_back(8'h85); dq1.push_back(8'hA3);
    m0 = '{8'h85, 8'h0F}; m1 = '{8'hA3};
    run_model(1'b1);
    wait_acc0(50, ok);
    repeat (10) tick();
    total += 4;
    if (!ok) begin bad++; $display("FAIL lock_first_accept got=timeout want=accept"); end
    if (lock_active !== 1'b1) begin bad++; $display("FAIL lock_held got=%b want=1", lock_active); end
    if (lock_owner !== 1'b0)  begin bad++; $display("FAIL lock_owner0 got=%b want=0", lock_owner); end
    if (acc1 != 0)            begin bad++; $display("FAIL lock_blocks_r1 got=%0d want=0", acc1); end
    dq0.push_back(8'h0F);
    wait_done(200, ok);
    total += 4;
    if (bus_log.size() != exp_q.size())
      begin bad++; $display("FAIL lock_count got=%0d want=%0d", bus_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
      total++;
      if (bus_log[i] !== exp_q[i]) begin bad++; $display("FAIL lock_order[%0d] got=%h want=%h", i, bus_log[i], exp_q[i]); end
    end
    if (lock_active !== exp_lk) begin bad++; $display("FAIL lock_final got=%b want=%b", lock_active, exp_lk); end
    if (lock_owner !== exp_own) begin bad++; $display("FAIL lock_final_owner got=%b want=%b", lock_owner, exp_own); end
    repeat (LTO + 4) tick();
    if (err !== {exp_lto, 1'b0}) begin bad++; $display("FAIL lock_final_err got=%b want=%b0", err, exp_lto); end
  endtask

  task automatic test_lock_timeout();
    bit ok;
    do_reset();
    dq0.push_back(8'h85);
    wait_acc0(50, ok);
    dq1.push_back(8'hB5);
    wait_done(200, ok); tick();
    total += 5;
    if (!ok) begin bad++; $display("FAIL lto_done got=timeout want=idle"); end
    if (lock_len != LTO) begin bad++; $display("FAIL lto_lock_cycles got=%0d want=%0d", lock_len, LTO); end
    if (err !== 2'b10)   begin bad++; $display("FAIL lto_err got=%b want=10", err); end
    if (acc1 != 1)       begin bad++; $display("FAIL lto_r1_granted got=%0d want=1", acc1); end
    if (bus_log.size() != 2 || bus_log[1] !== 8'hB5)
      begin bad++; $display("FAIL lto_order got=%0d/%h want=2/b5", bus_log.size(), bus_log[1]); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL err_clr got=%b want=00", err); end
  endtask

  task automatic test_strobe_timeout();
    bit ok;
    do_reset(); stuck = 1;
    dq0.push_back(8'h9F);
    wait_done(300, ok); tick();
    total += 4;
    if (!ok) begin bad++; $display("FAIL stb_done got=timeout want=idle"); end
    if (len_log.size() != 1 || len_log[0] != STB)
      begin bad++; $display("FAIL stb_len got=%0d want=%0d", len_log[0], STB); end
    if (err !== 2'b01) begin bad++; $display("FAIL stb_err got=%b want=01", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL stb_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n = 0;
    dq0.push_back(8'h85);
    while (psg_nWE && n < 50) begin tick(); n++; end
    tick(); tick();
    total++;
    if (n >= 50) begin bad++; $display("FAIL rmid_strobe got=timeout want=strobe"); end
    RST = 1'b1; #1;
    total += 6;
    if (psg_nWE !== 1'b1) begin bad++; $display("FAIL rmid_nWE got=%b want=1", psg_nWE); end
    if (psg_nCE !== 1'b1) begin bad++; $display("FAIL rmid_nCE got=%b want=1", psg_nCE); end
    if (psg_D !== 8'h00)  begin bad++; $display("FAIL rmid_D got=%h want=00", psg_D); end
    if (lock_active !== 1'b0) begin bad++; $display("FAIL rmid_lock got=%b want=0", lock_active); end
    if (err !== 2'b00)    begin bad++; $display("FAIL rmid_err got=%b want=00", err); end
    if (busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    stuck = 0;
    do_reset();
    dq0.push_back(8'h9F);
    wait_done(100, ok); tick();
    total += 3;
    if (bus_log.size() != 1 || bus_log[0] !== 8'h9F)
      begin bad++; $display("FAIL rmid_next got=%0d/%h want=1/9f", bus_log.size(), bus_log[0]); end
    if (len_log.size() != 1 || len_log[0] != dly)
      begin bad++; $display("FAIL rmid_next_len got=%0d want=%0d", len_log[0], dly); end
    if (err !== 2'b00) begin bad++; $display("FAIL rmid_next_err got=%b want=00", err); end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      do_reset(); dly = $urandom_range(1, 3);
      m0.delete(); m1.delete();
      for (int k = 0; k < 2; k++) begin
        int n = $urandom_range(3, 8);
        for (int j = 0; j < n; j++) begin
          case ($urandom_range(0, 3))
            0:       b = {1'b1, 2'($urandom_range(0, 2)), 1'b0, 4'($urandom)};
            1:       b = {1'b0, 7'($urandom)};
            default: b = 8'($urandom);
          endcase
          if (k == 0) begin m0.push_back(b); dq0.push_back(b); end
          else        begin m1.push_back(b); dq1.push_back(b); end
        end
      end
      run_model(1'b1);
      wait_done(3000, ok);
      repeat (LTO + 4) tick();
      total += 5;
      if (!ok) begin bad++; $display("FAIL rnd%0d_done got=timeout want=idle", it); end
      if (bus_log.size() != exp_q.size())
        begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, bus_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
        total++;
        if (bus_log[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_order[%0d] got=%h want=%h", it, i, bus_log[i], exp_q[i]); end
      end
      if (err !== {exp_lto, 1'b0}) begin bad++; $display("FAIL rnd%0d_err got=%b want=%b0", it, err, exp_lto); end
      if (lock_active !== 1'b0) begin bad++; $display("FAIL rnd%0d_lock got=%b want=0", it, lock_active); end
      if (mon_err != 0) begin bad++; $display("FAIL rnd%0d_bus_rules got=%0d want=0", it, mon_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_alternate();
    test_pair_lock();
    test_lock_timeout();
    test_strobe_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
